// File: rtl/m_max_relu_gen.sv
// Streaming max-pool + ReLU stage: folds WIN valid samples into one pooled value per write strobe,
// NUM_OUT outputs per frame. Optional argmax output enabled by `define MAX_RELU_ARGMAX_EN.
module m_max_relu_gen #(
  parameter  int DATA_W  = 16,
  parameter  int WIN     = 9,
  parameter  int NUM_OUT = 36,
  localparam int CNT_W   = $clog2(WIN),
  localparam int OUT_W   = $clog2(NUM_OUT + 1),
  localparam int IDX_W   = CNT_W
) (
  input  logic                     clk_in,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     relu_en,
  input  logic                     in_vld,
  input  logic signed [DATA_W-1:0] map_in,
  output logic signed [DATA_W-1:0] map_out,
  output logic                     wr,
  output logic                     ready
`ifdef MAX_RELU_ARGMAX_EN
  ,
  output logic        [IDX_W-1:0]  map_idx
`endif
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t                     state_q, state_d;
  logic signed [DATA_W-1:0]   tmp_max_q, tmp_max_d;
  logic signed [DATA_W-1:0]   map_out_q, map_out_d;
  logic        [CNT_W-1:0]    win_cnt_q, win_cnt_d;
  logic        [OUT_W-1:0]    out_cnt_q, out_cnt_d;
  logic                       wr_q, wr_d;
  logic                       ready_q, ready_d;

  logic signed [DATA_W-1:0]   seed_s;
  logic signed [DATA_W-1:0]   cur_max_s;
  logic                       beat_s;
  logic                       first_s;
  logic                       last_s;
  logic                       take_s;

  // The first sample of a window is compared against the live seed, so a relu_en change
  // between windows is honoured even though tmp_max was reloaded earlier.
  always_comb begin
    seed_s    = relu_en ? {DATA_W{1'b0}} : {1'b1, {(DATA_W-1){1'b0}}};
    first_s   = (win_cnt_q == {CNT_W{1'b0}});
    last_s    = (win_cnt_q == CNT_W'(WIN - 1));
    cur_max_s = first_s ? seed_s : tmp_max_q;
    beat_s    = (map_in > cur_max_s);
    take_s    = (state_q == ST_RUN) && in_vld && !start;
  end

  // Next-state for the window/frame datapath and FSM.
  always_comb begin
    state_d   = state_q;
    tmp_max_d = tmp_max_q;
    map_out_d = map_out_q;
    win_cnt_d = win_cnt_q;
    out_cnt_d = out_cnt_q;
    ready_d   = ready_q;
    wr_d      = 1'b0;
    if (start) begin
      state_d   = ST_RUN;
      tmp_max_d = seed_s;
      win_cnt_d = {CNT_W{1'b0}};
      out_cnt_d = {OUT_W{1'b0}};
      ready_d   = 1'b1;
    end else if (take_s) begin
      if (last_s) begin
        map_out_d = beat_s ? map_in : cur_max_s;
        wr_d      = 1'b1;
        tmp_max_d = seed_s;
        win_cnt_d = {CNT_W{1'b0}};
        out_cnt_d = out_cnt_q + OUT_W'(1);
        if (out_cnt_q == OUT_W'(NUM_OUT - 1)) begin
          ready_d = 1'b0;
          state_d = ST_DONE;
        end else begin
          ready_d = ready_q;
          state_d = ST_RUN;
        end
      end else begin
        tmp_max_d = beat_s ? map_in : cur_max_s;
        win_cnt_d = win_cnt_q + CNT_W'(1);
      end
    end else begin
      wr_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      tmp_max_q <= seed_s;
      map_out_q <= {DATA_W{1'b0}};
      win_cnt_q <= {CNT_W{1'b0}};
      out_cnt_q <= {OUT_W{1'b0}};
      wr_q      <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      tmp_max_q <= tmp_max_d;
      map_out_q <= map_out_d;
      win_cnt_q <= win_cnt_d;
      out_cnt_q <= out_cnt_d;
      wr_q      <= wr_d;
      ready_q   <= ready_d;
    end
  end

  assign map_out = map_out_q;
  assign wr      = wr_q;
  assign ready   = ready_q;

`ifdef MAX_RELU_ARGMAX_EN
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] map_idx_q, map_idx_d;
  logic [IDX_W-1:0] new_idx_s;

  // Position of the running max; only a strictly greater sample moves it.
  always_comb begin
    new_idx_s = beat_s ? win_cnt_q : (first_s ? {IDX_W{1'b0}} : idx_q);
    idx_d     = idx_q;
    map_idx_d = map_idx_q;
    if (start) begin
      idx_d = {IDX_W{1'b0}};
    end else if (take_s) begin
      if (last_s) begin
        map_idx_d = new_idx_s;
        idx_d     = {IDX_W{1'b0}};
      end else begin
        idx_d = new_idx_s;
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // Argmax registers.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      idx_q     <= {IDX_W{1'b0}};
      map_idx_q <= {IDX_W{1'b0}};
    end else begin
      idx_q     <= idx_d;
      map_idx_q <= map_idx_d;
    end
  end

  assign map_idx = map_idx_q;
`endif

endmodule
